// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-side memory bridge: MMIO map, access-size
// encoding, UART transmitter states and the store byte-lane helpers.
package dmem_bridge_pkg;

  localparam logic [31:0] MMIO_TXDATA  = 32'h1000_0000;
  localparam logic [31:0] MMIO_STATUS  = 32'h1000_0004;
  localparam logic [31:0] MMIO_CYC_LO  = 32'h1000_0008;
  localparam logic [31:0] MMIO_CYC_HI  = 32'h1000_000C;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } acc_size_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  function automatic logic misaligned_access(acc_size_t sz, logic [1:0] ofs);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return ofs[0];
      default: return ofs != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_strobe(acc_size_t sz, logic [1:0] ofs);
    case (sz)
      SZ_BYTE: return 4'b0001 << ofs;
      SZ_HALF: return ofs[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(acc_size_t sz, logic [31:0] wdata);
    case (sz)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bridge_uart_tx.sv
// UART 8N1 transmitter fed by a small TX FIFO; writes while full are dropped
// and flagged in a sticky overflow bit that a STATUS read clears.
module dmem_bridge_uart_tx
  import dmem_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_vld_i,
  input  logic [7:0] wr_dat_i,
  input  logic       status_rd_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       ovf_o,
  output logic       txd_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW+1)'(FIFO_DEPTH);

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          empty, full, push, pop, ovf_q;

  uart_state_t   state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          txd_q, baud_done;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FIFO_FULL);
  assign baud_done = (baud_q == '0);
  assign pop  = !empty && (state_q == UART_IDLE || (state_q == UART_STOP && baud_done));
  // A pop in the same cycle frees the slot, so a write on a full FIFO still lands.
  assign push = wr_vld_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= wr_dat_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (wr_vld_i && !push) ovf_q <= 1'b1;
      else if (status_rd_i)  ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        UART_IDLE: begin
          if (pop) begin
            state_q <= UART_START;
            baud_q  <= BAUD_LOAD;
            shift_q <= fifo_q[rptr_q];
            txd_q   <= 1'b0;
          end
        end
        UART_START: begin
          if (baud_done) begin
            state_q <= UART_DATA;
            baud_q  <= BAUD_LOAD;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        UART_DATA: begin
          if (baud_done) begin
            baud_q <= BAUD_LOAD;
            if (bit_q == 3'd7) begin
              state_q <= UART_STOP;
              txd_q   <= 1'b1;
            end else begin
              bit_q   <= bit_q + 1'b1;
              shift_q <= shift_q >> 1;
              txd_q   <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        UART_STOP: begin
          if (baud_done) begin
            if (pop) begin
              state_q <= UART_START;
              baud_q  <= BAUD_LOAD;
              shift_q <= fifo_q[rptr_q];
              txd_q   <= 1'b0;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            baud_q <= baud_q - 1'b1;
          end
        end
        default: state_q <= UART_IDLE;
      endcase
    end
  end

  assign full_o = full;
  assign busy_o = (state_q != UART_IDLE) || !empty;
  assign ovf_o  = ovf_q;
  assign txd_o  = txd_q;

endmodule

// File: rtl/dmem_bridge.sv
// Data-port bridge: byte steering, alignment check, data RAM, cycle counter and
// MMIO decode; the UART is built only when DMEM_UART_EN is defined.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int RAM_WORDS    = 1024,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] req_addr,
  input  logic        req_ren,
  input  logic        req_wen,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        misaligned,
  output logic        uart_txd
);
  localparam int AW = $clog2(RAM_WORDS);

  acc_size_t     size;
  logic          mis, rd_req, rd_go, wr_go, ram_sel;
  logic          sel_tx, sel_status, sel_lo, sel_hi;
  logic          tx_wr, status_rd;
  logic [AW-1:0] idx;
  logic [3:0]    strb;
  logic [31:0]   lanes, mmio_rdata, status_word;

  logic [31:0]   mem [RAM_WORDS];
  logic [31:0]   ram_rdata_q, rdata_q, cyc_hi_shadow_q;
  logic [63:0]   cycle_q, cycle_d;
  logic          from_ram_q, rvalid_q, mis_q;

  assign size       = acc_size_t'(req_size);
  assign mis        = misaligned_access(size, req_addr[1:0]);
  // A simultaneous read and write is a write; the read half is dropped entirely.
  assign rd_req     = req_ren & ~req_wen;
  assign rd_go      = rd_req & ~mis;
  assign wr_go      = req_wen & ~mis;
  assign ram_sel    = (req_addr[31:AW+2] == '0);
  assign idx        = req_addr[AW+1:2];
  assign strb       = byte_strobe(size, req_addr[1:0]);
  assign lanes      = store_lanes(size, req_wdata);
  assign sel_tx     = (req_addr[31:2] == MMIO_TXDATA[31:2]);
  assign sel_status = (req_addr[31:2] == MMIO_STATUS[31:2]);
  assign sel_lo     = (req_addr[31:2] == MMIO_CYC_LO[31:2]);
  assign sel_hi     = (req_addr[31:2] == MMIO_CYC_HI[31:2]);
  assign tx_wr      = wr_go & sel_tx;
  assign status_rd  = rd_go & sel_status;
  assign cycle_d    = cycle_q + 64'd1;

  always_ff @(posedge clk) begin
    if (wr_go && ram_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= lanes[8*b +: 8];
      end
    end
    if (rd_go && ram_sel) ram_rdata_q <= mem[idx];
  end

  always_comb begin
    mmio_rdata = '0;
    if (sel_status)  mmio_rdata = status_word;
    else if (sel_lo) mmio_rdata = cycle_q[31:0];
    else if (sel_hi) mmio_rdata = cyc_hi_shadow_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q         <= '0;
      cyc_hi_shadow_q <= '0;
      rdata_q         <= '0;
      from_ram_q      <= 1'b0;
      rvalid_q        <= 1'b0;
      mis_q           <= 1'b0;
    end else begin
      cycle_q  <= cycle_d;
      rvalid_q <= rd_req;
      mis_q    <= (req_ren | req_wen) & mis;
      if (rd_req) begin
        from_ram_q <= rd_go & ram_sel;
        rdata_q    <= (rd_go && !ram_sel) ? mmio_rdata : '0;
      end
      // Shadowing the high half on a LO read makes a LO-then-HI pair coherent.
      if (rd_go && sel_lo) cyc_hi_shadow_q <= cycle_q[63:32];
    end
  end

  assign rdata      = from_ram_q ? ram_rdata_q : rdata_q;
  assign rvalid     = rvalid_q;
  assign misaligned = mis_q;

`ifdef DMEM_UART_EN
  logic tx_full, tx_busy, tx_ovf;

  dmem_bridge_uart_tx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_vld_i   (tx_wr),
    .wr_dat_i   (req_wdata[7:0]),
    .status_rd_i(status_rd),
    .full_o     (tx_full),
    .busy_o     (tx_busy),
    .ovf_o      (tx_ovf),
    .txd_o      (uart_txd)
  );

  assign status_word = {29'd0, tx_ovf, tx_busy, tx_full};
`else
  logic unused_uart;
  assign unused_uart = ^{tx_wr, status_rd, 32'(FIFO_DEPTH), 32'(CLKS_PER_BIT)};
  assign status_word = '0;
  assign uart_txd    = 1'b1;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: vector table for RAM/MMIO accesses plus
// hand sequences for the cycle counter, UART framing, overflow and reset.
module tb_dmem_bridge;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] req_addr;
  logic        req_ren;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;
  logic        uart_txd;

  int total = 0;
  int bad   = 0;

  logic       mon_en = 1'b0;
  logic [7:0] rxq[$];

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_rvalid;
    logic        exp_mis;
  } vec_t;

  vec_t vt[$];

  dmem_bridge #(
    .RAM_WORDS   (1024),
    .FIFO_DEPTH  (8),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_addr  (req_addr),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .misaligned(misaligned),
    .uart_txd  (uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_req();
    req_ren   = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = 2'b10;
  endtask

  task automatic access(input logic ren, input logic wen, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz);
    req_ren   = ren;
    req_wen   = wen;
    req_addr  = a;
    req_wdata = d;
    req_size  = sz;
    cyc();
    clear_req();
  endtask

  task automatic add(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic [31:0] er, input logic erv, input logic em);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = a; v.wdata = d; v.size = sz;
    v.exp_rdata = er; v.exp_rvalid = erv; v.exp_mis = em;
    vt.push_back(v);
  endtask

  // Serial receiver: samples mid-bit, 4 clocks per bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && uart_txd === 1'b0) begin
        repeat (2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          repeat (4) @(negedge clk);
          b[j] = uart_txd;
        end
        repeat (4) @(negedge clk);
        rxq.push_back(b);
      end
    end
  end

  initial begin
    logic [7:0] txb;
    logic       exp_txd;
    int         lows;

    reset_n = 1'b0;
    clear_req();
    repeat (3) cyc();
    check("reset_rdata", rdata, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_mis", misaligned, 0);
    check("reset_txd", uart_txd, 1);

    // First edge out of reset sees the counter at 0.
    reset_n = 1'b1;
    access(1, 0, 32'h1000_0008, 0, 2'b10);
    check("cyc_lo_after_reset", rdata, 0);
    access(1, 0, 32'h1000_000C, 0, 2'b10);
    check("cyc_hi_after_reset", rdata, 0);

    add(0, 1, 32'h10,        32'hDEADBEEF, 2'b10, 0, 0, 0);
    add(0, 1, 32'h11,        32'hFFFFFF55, 2'b00, 0, 0, 0);
    add(1, 0, 32'h10,        0,            2'b10, 32'hDEAD55EF, 1, 0);
    add(0, 1, 32'h20,        32'h0BADF00D, 2'b10, 0, 0, 0);
    add(0, 1, 32'h22,        32'hFFFF1234, 2'b01, 0, 0, 0);
    add(1, 0, 32'h20,        0,            2'b10, 32'h1234F00D, 1, 0);
    add(0, 1, 32'h21,        32'h00009999, 2'b01, 0, 0, 1);
    add(1, 0, 32'h20,        0,            2'b10, 32'h1234F00D, 1, 0);
    add(1, 0, 32'h22,        0,            2'b10, 0, 1, 1);
    add(1, 1, 32'h30,        32'h11112222, 2'b10, 0, 0, 0);
    add(1, 0, 32'h30,        0,            2'b10, 32'h11112222, 1, 0);
    add(0, 1, 32'h30,        32'hAAAA5678, 2'b01, 0, 0, 0);
    add(0, 1, 32'h33,        32'h00000077, 2'b00, 0, 0, 0);
    add(1, 0, 32'h30,        0,            2'b10, 32'h77115678, 1, 0);
    add(0, 1, 32'h00,        32'h01020304, 2'b10, 0, 0, 0);
    add(0, 1, 32'h1000,      32'hFFFFFFFF, 2'b10, 0, 0, 0);
    add(1, 0, 32'h00,        0,            2'b10, 32'h01020304, 1, 0);
    add(1, 0, 32'h1000,      0,            2'b10, 0, 1, 0);
    add(1, 0, 32'h2000_0000, 0,            2'b10, 0, 1, 0);
    add(0, 1, 32'h40,        32'h89ABCDEF, 2'b11, 0, 0, 0);
    add(1, 0, 32'h40,        0,            2'b11, 32'h89ABCDEF, 1, 0);
    add(1, 0, 32'h13,        0,            2'b00, 32'hDEAD55EF, 1, 0);
    add(1, 0, 32'h1000_0004, 0,            2'b10, 0, 1, 0);
    add(1, 0, 32'h42,        0,            2'b01, 32'h89ABCDEF, 1, 0);
    add(1, 0, 32'h41,        0,            2'b01, 0, 1, 1);

    foreach (vt[i]) begin
      access(vt[i].ren, vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].size);
      check($sformatf("vec%0d_rvalid", i), rvalid, vt[i].exp_rvalid);
      check($sformatf("vec%0d_mis", i), misaligned, vt[i].exp_mis);
      if (vt[i].exp_rvalid) check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
    end

    // rdata holds across non-read cycles; rvalid is a single-cycle strobe.
    access(1, 0, 32'h10, 0, 2'b10);
    access(0, 1, 32'h50, 32'h1, 2'b10);
    check("hold_rvalid", rvalid, 0);
    check("hold_rdata", rdata, 32'hDEAD55EF);
    cyc();
    check("hold_rdata_idle", rdata, 32'hDEAD55EF);

    // Counter wrap of the low half, with the high half shadowed.
    req_ren  = 1'b1;
    req_addr = 32'h1000_0008;
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1 release dut.cycle_q;
    @(posedge clk);
    @(negedge clk);
    clear_req();
    check("cyc_lo_pre_wrap", rdata, 32'hFFFFFFFF);
    access(1, 0, 32'h1000_000C, 0, 2'b10);
    check("cyc_hi_shadow", rdata, 0);
    access(1, 0, 32'h1000_0008, 0, 2'b10);
    check("cyc_lo_post_wrap", rdata, 1);
    access(1, 0, 32'h1000_000C, 0, 2'b10);
    check("cyc_hi_post_wrap", rdata, 1);

`ifdef DMEM_UART_EN
    // Single frame 0xA5, checked cycle by cycle.
    txb = 8'hA5;
    access(0, 1, 32'h1000_0000, 32'h0000_00A5, 2'b10);
    check("tx_k0", uart_txd, 1);
    for (int k = 1; k <= 41; k++) begin
      if (k == 20) begin
        req_ren  = 1'b1;
        req_addr = 32'h1000_0004;
      end
      cyc();
      clear_req();
      if (k <= 4)       exp_txd = 1'b0;
      else if (k <= 36) exp_txd = txb[(k-5)/4];
      else              exp_txd = 1'b1;
      check($sformatf("tx_k%0d", k), uart_txd, exp_txd);
      if (k == 20) check("status_busy", rdata, 32'h2);
    end
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("status_idle", rdata, 0);

    // FIFO_DEPTH+2 back-to-back writes: one dropped, FIFO_DEPTH+1 frames sent.
    rxq.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) access(0, 1, 32'h1000_0000, 32'h30 + i, 2'b00);
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("status_full_ovf", rdata, 32'h7);
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("status_ovf_cleared", rdata, 32'h3);
    repeat (420) cyc();
    mon_en = 1'b0;
    check("frame_count", rxq.size(), 9);
    foreach (rxq[i]) check($sformatf("frame%0d", i), rxq[i], 8'h30 + i);
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("status_drained", rdata, 0);
`else
    access(0, 1, 32'h1000_0000, 32'h0000_00A5, 2'b10);
    lows = 0;
    for (int k = 0; k < 45; k++) begin
      cyc();
      if (uart_txd !== 1'b1) lows++;
    end
    check("txd_tied_high", lows, 0);
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("status_zero", rdata, 0);
`endif

    // Reset in the middle of a frame with bytes still queued.
    access(0, 1, 32'h1000_0000, 32'h11, 2'b00);
    access(0, 1, 32'h1000_0000, 32'h22, 2'b00);
    access(0, 1, 32'h1000_0000, 32'h33, 2'b00);
    repeat (13) cyc();
`ifdef DMEM_UART_EN
    check("txd_mid_frame_low", uart_txd, 0);
`endif
    reset_n  = 1'b0;
    req_ren  = 1'b1;
    req_addr = 32'h10;
    cyc();
    clear_req();
    check("rst_mid_txd", uart_txd, 1);
    check("rst_mid_rvalid", rvalid, 0);
    cyc();
    reset_n = 1'b1;
    access(1, 0, 32'h1000_0004, 0, 2'b10);
    check("rst_status", rdata, 0);
    lows = 0;
    for (int k = 0; k < 50; k++) begin
      cyc();
      if (uart_txd !== 1'b1) lows++;
    end
    check("rst_fifo_discarded", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory subsystem directly downstream of the multi-cycle RV32I core: consumes the core's data-port requests (address, read/write enables, store data, access size), performs byte-lane steering and alignment checking, and routes each access to an internal synchronous data RAM or a small MMIO region. The MMIO region holds a UART transmitter with a TX FIFO and a 64-bit free-running cycle counter. Load data is returned as the full aligned word; the core extracts the byte or halfword.

## Interface
- RAM_WORDS, 1024: data RAM depth in 32-bit words (power of two).
- FIFO_DEPTH, 8: UART TX FIFO entries (power of two, ≥2).
- CLKS_PER_BIT, 868: clk cycles per UART bit (≥2).
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- req_addr  in  32  byte address.
- req_ren  in  1  read request, single-cycle pulse.
- req_wen  in  1  write request, single-cycle pulse.
- req_wdata  in  32  store data, right-justified.
- req_size  in  2  00 byte, 01 halfword, 10 word (funct3[1:0]); 11 treated as word.
- rdata  out  32  aligned read word.
- rvalid  out  1  rdata valid strobe.
- misaligned  out  1  one-cycle error pulse.
- uart_txd  out  1  serial TX line, 8N1.

## Operation
- Address map: RAM at 0x0000_0000..4*RAM_WORDS-1; 0x1000_0000 UART TXDATA (write [7:0]); 0x1000_0004 UART STATUS (read: bit0 FIFO full, bit1 TX busy, bit2 overflow sticky); 0x1000_0008 CYCLE_LO; 0x1000_000C CYCLE_HI. Unmapped: reads return 0, writes ignored.
- Alignment: halfword with addr[0]=1 or word with addr[1:0]≠0 → access suppressed, misaligned=1 next cycle, rvalid=1 with rdata=0 if it was a read.
- Store steering: byte → wdata[7:0] replicated to 4 lanes, strobe 1<<addr[1:0]; halfword → wdata[15:0] replicated, strobe 0011 or 1100 per addr[1]; word → strobe 1111. Only strobed RAM bytes change.
- req_ren and req_wen together: treated as write only; no rvalid.
- UART TXDATA write with FIFO full: byte dropped, overflow set. STATUS read clears overflow; a same-cycle set wins over clear.
- UART FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE. In IDLE with FIFO non-empty: pop, enter START next cycle. Each state lasts CLKS_PER_BIT cycles (baud counter loads CLKS_PER_BIT-1, counts to 0). Bit counter 0..7 in DATA. Busy = state≠IDLE or FIFO non-empty. Back-to-back bytes: STOP → START with no idle gap when FIFO non-empty.
- Cycle counter: 64-bit, 0 after reset, +1 per cycle, wraps to 0. Reading CYCLE_LO latches the upper 32 bits into a shadow; CYCLE_HI returns the shadow, giving a coherent pair when read LO then HI.
- RAM contents are not reset.

## Timing
- Read latency 1: request at edge N → rdata/rvalid valid after edge N+1; rvalid high exactly one cycle; rdata holds until the next read.
- Writes posted; RAM write visible to a read issued the following cycle.
- Reset values: rdata 0, rvalid 0, misaligned 0, uart_txd 1, FIFO empty, overflow 0, counter 0, UART in IDLE. Reset mid-frame: txd returns to 1 at the next edge; pending FIFO bytes are discarded.
- FIFO full and pop in the same cycle: a TXDATA write is accepted (no overflow).

## Configuration
- DMEM_UART_EN defined: UART FIFO and transmitter are built as described.
- Not defined: no UART logic is built; uart_txd is tied to 1, TXDATA writes are ignored, and STATUS reads 0. RAM and the cycle counter are unchanged.

## Structure
- The shared definitions package holds the MMIO address constants, the access-size encoding, and the UART state enum (uart_state_t).
- Sub-module uart_tx holds the FIFO and the 8N1 FSM, and is instantiated only under DMEM_UART_EN. RAM, decode, and the counter live in dmem_bridge.

## Test plan
- Word write 0xDEADBEEF @0x10, then byte write 0x55 @0x11, then word read @0x10 → rdata 0xDEAD55EF, rvalid one cycle after the request.
- Halfword write 0x1234 @0x22, then read @0x20 → 0x1234xxxx with the lower half unchanged. Halfword write @0x21 → misaligned pulse, RAM unchanged.
- CLKS_PER_BIT=4: write 0xA5 to TXDATA → txd low for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high stop; STATUS bit1 clears after the stop bit.
- Write FIFO_DEPTH+2 bytes back-to-back → STATUS reads full=1 and overflow=1; a second STATUS read shows overflow=0; exactly FIFO_DEPTH+1 frames are transmitted, because the first pop frees a slot.
- Read CYCLE_LO and CYCLE_HI after forcing the counter to 0x0000_0000_FFFF_FFFF → LO 0xFFFFFFFF, HI 0 (shadowed); after wrap the counter increments normally.
- Reset asserted mid-DATA state → txd 1, rvalid 0, and STATUS reads 0 after release.
